adc_spi_capture: RTL and testbench

Serial ADC capture stage feeding `sample_dat`/`ack_i` of `analog_front_end`. Paces conversions with a sample-rate timer. Each conversion runs one SPI read frame on a 16-bit serial ADC (CPOL=1, data captured on SCLK rising edge). The result is presented as a parallel word with a one-cycle valid pulse, gated by the consumer's ready (`req`).

---
 rtl/adc_spi_capture.sv | 199 +++++++++++++++++++
 tb/tb_adc_spi_capture.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_capture.sv
// adc_spi_capture
//   Paces conversions of a 16-bit serial ADC with a free-running sample-rate
//   timer. Each conversion runs one SPI read frame (CPOL=1, data sampled on
//   the SCLK rising edge). The captured word is presented on sample_dat
//   together with a one-cycle ack_o pulse, gated by the consumer's req_i.
//
// Ports
//   clk, rst_n       system clock, asynchronous active-low reset
//   enable           allows new conversions to start on a timer tick
//   req_i            downstream ready
//   ack_o            one-cycle pulse: sample_dat holds a new word
//   sample_dat[15:0] last captured word, MSB-first assembled
//   busy_o           high while a frame is in progress
//   overrun_o        sticky: a new word overwrote an undelivered one
//   overrun_clr      synchronous clear of overrun_o (a set event wins)
//   adc_cs_n         ADC chip select, active-low
//   adc_sclk         ADC serial clock, idle high
//   adc_sdo          ADC serial data, changes on SCLK falling edge
module adc_spi_capture #(
    parameter int CLK_DIV       = 4,
    parameter int FRAME_BITS    = 16,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        req_i,
    output logic        ack_o,
    output logic [15:0] sample_dat,
    output logic        busy_o,
    output logic        overrun_o,
    input  logic        overrun_clr,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    input  logic        adc_sdo
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam int CNT_W = $clog2(SAMPLE_PERIOD);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        QUIET,
        DELIVER
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               half_q, half_d;     // 0: SCLK low half, 1: high half
    logic [15:0]        shift_q, shift_d;
    logic [15:0]        sample_q, sample_d;
    logic               pending_q, pending_d;
    logic               ack_q, ack_d;
    logic               overrun_q, overrun_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               busy_q, busy_d;

    logic               tick;
    logic               div_end;
    logic               load;
    logic               avail;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        half_d    = half_q;
        shift_d   = shift_q;
        load      = 1'b0;

        tick      = (cnt_q == CNT_W'(SAMPLE_PERIOD - 1));
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        div_end   = (div_q == DIV_W'(CLK_DIV - 1));

        unique case (state_q)
            IDLE: begin
                if (tick && enable) begin
                    state_d = SETUP;
                    div_d   = '0;
                end
            end
            SETUP: begin
                if (div_end) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    half_d  = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                if (div_end) begin
                    div_d = '0;
                    if (!half_q) begin
                        // Low half ends: SCLK rises and the data bit is taken
                        // on this same edge. Old bits fall off the top.
                        half_d  = 1'b1;
                        shift_d = {shift_q[14:0], adc_sdo};
                    end else if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
                        state_d = HOLD;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        half_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_end) begin
                    state_d = QUIET;
                    div_d   = '0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            QUIET: begin
                if (div_end) begin
                    // The word becomes visible in the DELIVER cycle itself.
                    state_d = DELIVER;
                    div_d   = '0;
                    load    = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DELIVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        sample_d  = load ? shift_q : sample_q;

        // A freshly loaded word is acked on the same edge if req_i is high;
        // otherwise it waits as pending until the first cycle req_i is high.
        avail     = pending_q | load;
        ack_d     = avail & req_i;
        pending_d = avail & ~req_i;
        overrun_d = (load & pending_q) | (overrun_q & ~overrun_clr);

        // Pin outputs are decoded from the next state so they are flops that
        // line up exactly with the state register.
        cs_n_d    = !(state_d inside {SETUP, SHIFT, HOLD});
        sclk_d    = !(state_d == SHIFT && !half_d);
        busy_d    = (state_d != IDLE);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values; the asynchronous reset puts the pins in their idle
    // levels immediately, abandoning any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_q     <= '0;
            half_q    <= 1'b0;
            shift_q   <= '0;
            sample_q  <= '0;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            overrun_q <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            half_q    <= half_d;
            shift_q   <= shift_d;
            sample_q  <= sample_d;
            pending_q <= pending_d;
            ack_q     <= ack_d;
            overrun_q <= overrun_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
        end
    end

    assign ack_o      = ack_q;
    assign sample_dat = sample_q;
    assign busy_o     = busy_q;
    assign overrun_o  = overrun_q;
    assign adc_cs_n   = cs_n_q;
    assign adc_sclk   = sclk_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Testbench for adc_spi_capture: a default-parameter instance (u_dut0) and a
// corner instance (u_dut1: CLK_DIV=2, FRAME_BITS=18, SAMPLE_PERIOD=80). Each
// has an ADC model that serves frames from a word table and a monitor that
// logs pin activity; expected timing comes from the frame arithmetic.
module tb_adc_spi_capture;

    localparam int CD0 = 4, FB0 = 16, SP0 = 1000;
    localparam int LAT0 = 1 + CD0 * (2 * FB0 + 3);
    localparam int CD1 = 2, FB1 = 18, SP1 = 80;
    localparam int LAT1 = 1 + CD1 * (2 * FB1 + 3);

    logic clk;
    logic rst_n, enable, req_i, overrun_clr, adc_sdo0;
    logic ack0, busy0, overrun0, cs_n0, sclk0;
    logic [15:0] sample0;
    logic rst1_n, enable1, req1, clr1, adc_sdo1;
    logic ack1, busy1, overrun1, cs_n1, sclk1;
    logic [15:0] sample1;

    int checks, failures;
    int cyc;
    int r0, r1;

    logic [FB0-1:0] word_tab0 [64];
    logic [FB1-1:0] word_tab1 [64];

    // monitor logs (written only by the monitors)
    int csf_cyc0 [64];
    int csf_n0, csr_last0, rises0, sclk_bad0, ack_n0, rd0, bit0;
    int ack_cyc0 [64];
    logic [15:0] ack_dat0 [64];
    int ack_rise0 [64];
    logic [FB0-1:0] frm0;
    logic prev_cs0, prev_sclk0;

    int csf_n1, rises1, sclk_bad1, ack_n1, rd1, bit1;
    int ack_cyc1 [64];
    logic [15:0] ack_dat1 [64];
    int ack_rise1 [64];
    logic [FB1-1:0] frm1;
    logic prev_cs1, prev_sclk1;

    adc_spi_capture u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_i(req_i),
        .ack_o(ack0), .sample_dat(sample0), .busy_o(busy0),
        .overrun_o(overrun0), .overrun_clr(overrun_clr),
        .adc_cs_n(cs_n0), .adc_sclk(sclk0), .adc_sdo(adc_sdo0)
    );

    adc_spi_capture #(.CLK_DIV(CD1), .FRAME_BITS(FB1), .SAMPLE_PERIOD(SP1)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .enable(enable1), .req_i(req1),
        .ack_o(ack1), .sample_dat(sample1), .busy_o(busy1),
        .overrun_o(overrun1), .overrun_clr(clr1),
        .adc_cs_n(cs_n1), .adc_sclk(sclk1), .adc_sdo(adc_sdo1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // ADC model + monitor, default instance: the k-th SCLK fall of a frame
    // presents bit FB-1-k, so each rising edge samples the next MSB-first bit.
    initial begin
        csf_n0 = 0; csr_last0 = 0; rises0 = 0; sclk_bad0 = 0; ack_n0 = 0;
        rd0 = 0; bit0 = -1; frm0 = '0; prev_cs0 = 1'b1; prev_sclk0 = 1'b1;
        adc_sdo0 = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_cs0 && !cs_n0) begin
                if (csf_n0 < 64) csf_cyc0[csf_n0] = cyc;
                csf_n0 = csf_n0 + 1;
                frm0 = word_tab0[rd0 % 64];
                rd0 = rd0 + 1;
                bit0 = FB0 - 1;
                rises0 = 0;
            end
            if (!prev_cs0 && cs_n0) csr_last0 = cyc;
            if (!cs_n0 && prev_sclk0 && !sclk0 && bit0 >= 0) begin
                adc_sdo0 = frm0[bit0];
                bit0 = bit0 - 1;
            end
            if (!cs_n0 && !prev_sclk0 && sclk0) rises0 = rises0 + 1;
            if (cs_n0 && !sclk0) sclk_bad0 = sclk_bad0 + 1;
            if (ack0) begin
                if (ack_n0 < 64) begin
                    ack_cyc0[ack_n0] = cyc;
                    ack_dat0[ack_n0] = sample0;
                    ack_rise0[ack_n0] = rises0;
                end
                ack_n0 = ack_n0 + 1;
            end
            prev_cs0 = cs_n0;
            prev_sclk0 = sclk0;
        end
    end

    // ADC model + monitor, corner instance.
    initial begin
        csf_n1 = 0; rises1 = 0; sclk_bad1 = 0; ack_n1 = 0;
        rd1 = 0; bit1 = -1; frm1 = '0; prev_cs1 = 1'b1; prev_sclk1 = 1'b1;
        adc_sdo1 = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_cs1 && !cs_n1) begin
                csf_n1 = csf_n1 + 1;
                frm1 = word_tab1[rd1 % 64];
                rd1 = rd1 + 1;
                bit1 = FB1 - 1;
                rises1 = 0;
            end
            if (!cs_n1 && prev_sclk1 && !sclk1 && bit1 >= 0) begin
                adc_sdo1 = frm1[bit1];
                bit1 = bit1 - 1;
            end
            if (!cs_n1 && !prev_sclk1 && sclk1) rises1 = rises1 + 1;
            if (cs_n1 && !sclk1) sclk_bad1 = sclk_bad1 + 1;
            if (ack1) begin
                if (ack_n1 < 64) begin
                    ack_cyc1[ack_n1] = cyc;
                    ack_dat1[ack_n1] = sample1;
                    ack_rise1[ack_n1] = rises1;
                end
                ack_n1 = ack_n1 + 1;
            end
            prev_cs1 = cs_n1;
            prev_sclk1 = sclk1;
        end
    end

    // Delivery cycle of the k-th timer tick after the last release of rst_n.
    function automatic int dl0(input int k);
        return r0 + SP0 - 1 + LAT0 + k * SP0;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_ack0(input int target, input int budget, output bit ok);
        int n = 0;
        while (ack_n0 < target && n < budget) begin
            step();
            n++;
        end
        ok = (ack_n0 >= target);
    endtask

    task automatic wait_ack1(input int target, input int budget, output bit ok);
        int n = 0;
        while (ack_n1 < target && n < budget) begin
            step();
            n++;
        end
        ok = (ack_n1 >= target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst1_n = 1'b0;
        enable = 1'b0; req_i = 1'b0; overrun_clr = 1'b0;
        enable1 = 1'b1; req1 = 1'b1; clr1 = 1'b0;
        repeat (3) step();
        checks++; if (cs_n0 !== 1'b1) begin failures++; $display("FAIL reset_cs_n: got %b want 1", cs_n0); end
        checks++; if (sclk0 !== 1'b1) begin failures++; $display("FAIL reset_sclk: got %b want 1", sclk0); end
        checks++; if (sample0 !== 16'h0000) begin failures++; $display("FAIL reset_sample: got %h want 0000", sample0); end
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", ack0); end
        checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy0); end
        checks++; if (overrun0 !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun0); end
        checks++; if (cs_n1 !== 1'b1 || sclk1 !== 1'b1) begin failures++; $display("FAIL reset_pins1: got cs_n=%b sclk=%b want 1 1", cs_n1, sclk1); end
        enable = 1'b1; req_i = 1'b1;
        rst_n = 1'b1;
        r0 = cyc;
    endtask

    task automatic test_basic();
        bit ok;
        wait_ack0(1, SP0 + LAT0 + 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout: got %0d acks want 1", ack_n0); end
        if (ok) begin
            checks++; if (csf_cyc0[0] !== r0 + SP0) begin failures++; $display("FAIL basic_cs_fall: got %0d want %0d", csf_cyc0[0], r0 + SP0); end
            checks++; if (ack_cyc0[0] !== dl0(0)) begin failures++; $display("FAIL basic_latency: got %0d want %0d", ack_cyc0[0], dl0(0)); end
            checks++; if (ack_dat0[0] !== 16'hA5C3) begin failures++; $display("FAIL basic_data: got %h want a5c3", ack_dat0[0]); end
            checks++; if (ack_rise0[0] !== 16) begin failures++; $display("FAIL basic_rises: got %0d want 16", ack_rise0[0]); end
            checks++; if (csr_last0 !== r0 + SP0 + CD0 * (2 * FB0 + 2)) begin failures++; $display("FAIL basic_cs_rise: got %0d want %0d", csr_last0, r0 + SP0 + CD0 * (2 * FB0 + 2)); end
            checks++; if (busy0 !== 1'b1) begin failures++; $display("FAIL basic_busy_deliver: got %b want 1", busy0); end
            step();
            checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL basic_busy_after: got %b want 0", busy0); end
            repeat (20) step();
            checks++; if (ack_n0 !== 1) begin failures++; $display("FAIL basic_single_ack: got %0d want 1", ack_n0); end
        end
    endtask

    task automatic test_rate();
        bit ok;
        wait_ack0(9, 8 * SP0 + 300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rate_timeout: got %0d acks want 9", ack_n0); end
        if (ok) begin
            for (int i = 1; i < 9; i++) begin
                checks++; if (ack_cyc0[i] - ack_cyc0[i-1] !== SP0) begin failures++; $display("FAIL rate_spacing[%0d]: got %0d want %0d", i, ack_cyc0[i] - ack_cyc0[i-1], SP0); end
                checks++; if (ack_dat0[i] !== word_tab0[i]) begin failures++; $display("FAIL rate_data[%0d]: got %h want %h", i, ack_dat0[i], word_tab0[i]); end
                checks++; if (ack_rise0[i] !== 16) begin failures++; $display("FAIL rate_rises[%0d]: got %0d want 16", i, ack_rise0[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int c;
        req_i = 1'b0;
        wait_until(dl0(9) + 2);
        checks++; if (sample0 !== word_tab0[9]) begin failures++; $display("FAIL bp_first_word: got %h want %h", sample0, word_tab0[9]); end
        checks++; if (overrun0 !== 1'b0) begin failures++; $display("FAIL bp_no_overrun_yet: got %b want 0", overrun0); end
        wait_until(dl0(10) + 2);
        checks++; if (sample0 !== word_tab0[10]) begin failures++; $display("FAIL bp_second_word: got %h want %h", sample0, word_tab0[10]); end
        checks++; if (overrun0 !== 1'b1) begin failures++; $display("FAIL bp_overrun: got %b want 1", overrun0); end
        checks++; if (ack_n0 !== 9) begin failures++; $display("FAIL bp_no_ack: got %0d acks want 9", ack_n0); end
        c = cyc;
        req_i = 1'b1;
        step();
        checks++; if (ack_n0 !== 10 || ack_cyc0[9] !== c + 1) begin failures++; $display("FAIL bp_release_ack: got %0d acks at %0d want 10 at %0d", ack_n0, ack_cyc0[9], c + 1); end
        checks++; if (ack_dat0[9] !== word_tab0[10]) begin failures++; $display("FAIL bp_release_data: got %h want %h", ack_dat0[9], word_tab0[10]); end
        repeat (3) step();
        checks++; if (ack_n0 !== 10) begin failures++; $display("FAIL bp_one_ack: got %0d want 10", ack_n0); end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        checks++; if (overrun0 !== 1'b0) begin failures++; $display("FAIL bp_clear: got %b want 0", overrun0); end
        // A clear requested in the same cycle as an overrun event must lose.
        req_i = 1'b0;
        wait_until(dl0(11) + 2);
        checks++; if (overrun0 !== 1'b0 || sample0 !== word_tab0[11]) begin failures++; $display("FAIL bp_pending: got ovr=%b dat=%h want 0 %h", overrun0, sample0, word_tab0[11]); end
        wait_until(dl0(12) - 2);
        overrun_clr = 1'b1;
        wait_until(dl0(12));
        overrun_clr = 1'b0;
        checks++; if (overrun0 !== 1'b1) begin failures++; $display("FAIL bp_set_wins: got %b want 1", overrun0); end
        checks++; if (sample0 !== word_tab0[12]) begin failures++; $display("FAIL bp_set_wins_data: got %h want %h", sample0, word_tab0[12]); end
        req_i = 1'b1;
        step();
        checks++; if (ack_n0 !== 11 || ack_dat0[10] !== word_tab0[12]) begin failures++; $display("FAIL bp_drain: got %0d acks dat=%h want 11 %h", ack_n0, ack_dat0[10], word_tab0[12]); end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
    endtask

    task automatic test_enable();
        int t, e, k;
        t = r0 + SP0 - 1 + 13 * SP0;
        wait_until(t + 1 + 20);
        enable = 1'b0;
        checks++; if (busy0 !== 1'b1 || csf_n0 !== 14) begin failures++; $display("FAIL en_in_frame: got busy=%b starts=%0d want 1 14", busy0, csf_n0); end
        wait_until(dl0(13) + 1);
        checks++; if (ack_n0 !== 12 || ack_cyc0[11] !== dl0(13)) begin failures++; $display("FAIL en_delivered: got %0d acks at %0d want 12 at %0d", ack_n0, ack_cyc0[11], dl0(13)); end
        checks++; if (ack_dat0[11] !== word_tab0[13]) begin failures++; $display("FAIL en_data: got %h want %h", ack_dat0[11], word_tab0[13]); end
        wait_until(dl0(15) + 10);
        checks++; if (csf_n0 !== 14) begin failures++; $display("FAIL en_no_start: got %0d starts want 14", csf_n0); end
        e = cyc + $urandom_range(1, SP0 - 1);
        wait_until(e);
        enable = 1'b1;
        k = (e - (r0 + SP0 - 1) + SP0 - 1) / SP0;
        t = r0 + SP0 - 1 + k * SP0;
        wait_until(t + 2);
        checks++; if (csf_n0 !== 15 || csf_cyc0[14] !== t + 1) begin failures++; $display("FAIL en_realign: got %0d starts at %0d want 15 at %0d", csf_n0, csf_cyc0[14], t + 1); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        bit ok;
        while (rises0 < 7 && n < 200) begin
            step();
            n++;
        end
        checks++; if (rises0 < 7) begin failures++; $display("FAIL ar_reach_bit: got %0d rises want 7", rises0); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (cs_n0 !== 1'b1 || sclk0 !== 1'b1) begin failures++; $display("FAIL ar_pins: got cs_n=%b sclk=%b want 1 1", cs_n0, sclk0); end
        checks++; if (sample0 !== 16'h0000 || busy0 !== 1'b0) begin failures++; $display("FAIL ar_state: got dat=%h busy=%b want 0000 0", sample0, busy0); end
        step();
        step();
        rst_n = 1'b1;
        r0 = cyc;
        wait_until(r0 + SP0 - 1);
        checks++; if (csf_n0 !== 15) begin failures++; $display("FAIL ar_quiet: got %0d starts want 15", csf_n0); end
        wait_until(r0 + SP0 + 1);
        checks++; if (csf_n0 !== 16 || csf_cyc0[15] !== r0 + SP0) begin failures++; $display("FAIL ar_first_start: got %0d starts at %0d want 16 at %0d", csf_n0, csf_cyc0[15], r0 + SP0); end
        wait_ack0(13, LAT0 + 50, ok);
        checks++; if (!ok || ack_cyc0[12] !== dl0(0)) begin failures++; $display("FAIL ar_deliver: got %0d acks at %0d want 13 at %0d", ack_n0, ack_cyc0[12], dl0(0)); end
        checks++; if (ack_dat0[12] !== word_tab0[15]) begin failures++; $display("FAIL ar_data: got %h want %h", ack_dat0[12], word_tab0[15]); end
    endtask

    task automatic test_corner();
        bit ok;
        rst1_n = 1'b1;
        r1 = cyc;
        wait_ack1(6, 6 * SP1 + LAT1 + 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL corner_timeout: got %0d acks want 6", ack_n1); end
        if (ok) begin
            checks++; if (ack_dat1[0] !== 16'hBEEF) begin failures++; $display("FAIL corner_beef: got %h want beef", ack_dat1[0]); end
            for (int i = 0; i < 6; i++) begin
                checks++; if (ack_cyc1[i] !== r1 + SP1 - 1 + LAT1 + i * SP1) begin failures++; $display("FAIL corner_time[%0d]: got %0d want %0d", i, ack_cyc1[i], r1 + SP1 - 1 + LAT1 + i * SP1); end
                checks++; if (ack_dat1[i] !== word_tab1[i][15:0]) begin failures++; $display("FAIL corner_data[%0d]: got %h want %h", i, ack_dat1[i], word_tab1[i][15:0]); end
                checks++; if (ack_rise1[i] !== FB1) begin failures++; $display("FAIL corner_rises[%0d]: got %0d want %0d", i, ack_rise1[i], FB1); end
            end
        end
        checks++; if (sclk_bad0 !== 0 || sclk_bad1 !== 0) begin failures++; $display("FAIL sclk_idle_high: got %0d/%0d low cycles want 0", sclk_bad0, sclk_bad1); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) begin
            word_tab0[i] = FB0'($urandom);
            word_tab1[i] = FB1'($urandom);
        end
        word_tab0[0] = 16'hA5C3;
        word_tab0[1] = 16'h0000;
        word_tab0[2] = 16'hFFFF;
        word_tab0[3] = 16'h8001;
        word_tab0[4] = 16'h7FFE;
        word_tab0[5] = 16'h1234;
        word_tab1[0] = {2'b00, 16'hBEEF};
        test_reset();
        test_basic();
        test_rate();
        test_backpressure();
        test_enable();
        test_async_reset();
        test_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
